// File: rtl/full_adder_checker_if.sv
// full_adder_checker_if: stimulus/response and scoreboard status bundle for the full-adder checker
interface full_adder_checker_if #(parameter int CNT_W = 8);
  logic start, stop, valid, A, B, Cin, S, Cout;
  logic busy, done, mismatch, fail_seen, all_pass;
  logic [CNT_W-1:0] pass_count, fail_count;
  logic [7:0] coverage;
  logic [4:0] first_fail;
  modport master (
    output start, stop, valid, A, B, Cin, S, Cout,
    input busy, done, mismatch, pass_count, fail_count, coverage, fail_seen, first_fail, all_pass
  );
  modport slave (
    input start, stop, valid, A, B, Cin, S, Cout,
    output busy, done, mismatch, pass_count, fail_count, coverage, fail_seen, first_fail, all_pass
  );
endinterface

// File: rtl/full_adder_checker.sv
// full_adder_checker: scores full-adder responses, tracks input coverage and latches the first failure
module full_adder_checker #(
  parameter int CNT_W = 8,
  parameter int MIN_SAMPLES = 8,
  parameter bit STOP_ON_FAIL = 1'b0
) (
  input logic clk,
  input logic rst,
  full_adder_checker_if.slave bus
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  localparam logic [CNT_W-1:0] MAX = '1;
  state_t state, state_nx;
  logic [CNT_W-1:0] pass_q, fail_q, smp_q, smp_nx;
  logic [7:0] cov_q, cov_nx;
  logic [4:0] ff_q;
  logic seen_q, mis_q, exp_s, exp_c, hit, miss;
  always_comb begin
    exp_s = bus.A ^ bus.B ^ bus.Cin;
    exp_c = (bus.A & bus.B) | (bus.A & bus.Cin) | (bus.B & bus.Cin);
    hit = state == RUN && bus.valid && !bus.start;
    miss = hit && (bus.S != exp_s || bus.Cout != exp_c);
    cov_nx = cov_q | (hit ? 8'b1 << {bus.A, bus.B, bus.Cin} : 8'b0);
    smp_nx = hit && smp_q != MAX ? smp_q + 1'b1 : smp_q;
    state_nx = state;
    if (bus.start)
      state_nx = RUN;
    else if (state == RUN && (bus.stop || (cov_nx == 8'hFF && smp_nx >= CNT_W'(MIN_SAMPLES)) || (STOP_ON_FAIL && miss)))
      state_nx = DONE;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      mis_q <= 1'b0;
      pass_q <= '0;
      fail_q <= '0;
      smp_q <= '0;
      cov_q <= '0;
      ff_q <= '0;
      seen_q <= 1'b0;
    end else begin
      state <= state_nx;
      mis_q <= miss;
      if (bus.start) begin
        pass_q <= '0;
        fail_q <= '0;
        smp_q <= '0;
        cov_q <= '0;
        ff_q <= '0;
        seen_q <= 1'b0;
      end else if (hit) begin
        pass_q <= !miss && pass_q != MAX ? pass_q + 1'b1 : pass_q;
        fail_q <= miss && fail_q != MAX ? fail_q + 1'b1 : fail_q;
        smp_q <= smp_nx;
        cov_q <= cov_nx;
        if (miss && !seen_q) begin
          seen_q <= 1'b1;
          ff_q <= {bus.A, bus.B, bus.Cin, bus.S, bus.Cout};
        end
      end
    end
  end
  assign bus.busy = state == RUN;
  assign bus.done = state == DONE;
  assign bus.mismatch = mis_q;
  assign bus.pass_count = pass_q;
  assign bus.fail_count = fail_q;
  assign bus.coverage = cov_q;
  assign bus.fail_seen = seen_q;
  assign bus.first_fail = ff_q;
  assign bus.all_pass = state == DONE && fail_q == '0 && cov_q == 8'hFF;
endmodule

// File: tb/tb_full_adder_checker.sv
// tb_full_adder_checker: drives three checker variants in lockstep, scoreboards dut0 mismatch pulses
module tb_full_adder_checker;
  logic clk, rst, start, stop, valid, a, b, cin, s, cout, run_exp;
  int n_cmp, n_bad;
  logic exp_q[$];
  full_adder_checker_if #(.CNT_W(8)) if0 ();
  full_adder_checker_if #(.CNT_W(8)) if1 ();
  full_adder_checker_if #(.CNT_W(3)) if2 ();
  full_adder_checker #(.CNT_W(8), .MIN_SAMPLES(8), .STOP_ON_FAIL(1'b0)) dut0 (.clk(clk), .rst(rst), .bus(if0.slave));
  full_adder_checker #(.CNT_W(8), .MIN_SAMPLES(8), .STOP_ON_FAIL(1'b1)) dut1 (.clk(clk), .rst(rst), .bus(if1.slave));
  full_adder_checker #(.CNT_W(3), .MIN_SAMPLES(7), .STOP_ON_FAIL(1'b0)) dut2 (.clk(clk), .rst(rst), .bus(if2.slave));
  always_comb begin
    {if0.start, if0.stop, if0.valid, if0.A, if0.B, if0.Cin, if0.S, if0.Cout} = {start, stop, valid, a, b, cin, s, cout};
    {if1.start, if1.stop, if1.valid, if1.A, if1.B, if1.Cin, if1.S, if1.Cout} = {start, stop, valid, a, b, cin, s, cout};
    {if2.start, if2.stop, if2.valid, if2.A, if2.B, if2.Cin, if2.S, if2.Cout} = {start, stop, valid, a, b, cin, s, cout};
  end
  always #5 clk = ~clk;
  function automatic logic [1:0] fa(input logic [2:0] v);
    return {^v, (v[2] & v[1]) | (v[2] & v[0]) | (v[1] & v[0])};
  endfunction
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic drive(input logic st, input logic sp, input logic v, input logic [2:0] abc, input logic [1:0] sc);
    start = st;
    stop = sp;
    valid = v;
    {a, b, cin} = abc;
    {s, cout} = sc;
    exp_q.push_back(!rst && run_exp && v && !st && sc != fa(abc));
    @(posedge clk);
    #1;
    if (rst) run_exp = 1'b0;
    else if (st) run_exp = 1'b1;
    else if (sp) run_exp = 1'b0;
    chk("mismatch", if0.mismatch, exp_q.pop_front());
  endtask
  task automatic idle();
    drive(1'b0, 1'b0, 1'b0, 3'b000, 2'b00);
  endtask
  task automatic good(input logic [2:0] v);
    drive(1'b0, 1'b0, 1'b1, v, fa(v));
  endtask
  initial begin
    logic [2:0] vecs [6];
    vecs = '{3'b000, 3'b010, 3'b001, 3'b110, 3'b101, 3'b111};
    n_cmp = 0;
    n_bad = 0;
    clk = 1'b0;
    rst = 1'b1;
    run_exp = 1'b0;
    {start, stop, valid, a, b, cin, s, cout} = '0;
    idle();
    good(3'b000);
    rst = 1'b0;
    chk("rst_busy", if0.busy, 0);
    chk("rst_done", if0.done, 0);
    chk("rst_pass", if0.pass_count, 0);
    chk("rst_fail", if0.fail_count, 0);
    chk("rst_cov", if0.coverage, 0);
    chk("rst_seen", if0.fail_seen, 0);
    chk("rst_ff", if0.first_fail, 0);
    chk("rst_allpass", if0.all_pass, 0);
    good(3'b011);
    chk("idle_valid_ignored", if0.pass_count, 0);
    drive(1'b1, 1'b0, 1'b0, 3'b000, 2'b00);
    chk("start_busy", if0.busy, 1);
    foreach (vecs[i]) good(vecs[i]);
    drive(1'b0, 1'b1, 1'b0, 3'b000, 2'b00);
    chk("t1_pass", if0.pass_count, 6);
    chk("t1_fail", if0.fail_count, 0);
    chk("t1_cov", if0.coverage, 8'hE7);
    chk("t1_done", if0.done, 1);
    chk("t1_busy", if0.busy, 0);
    chk("t1_allpass", if0.all_pass, 0);
    good(3'b100);
    chk("done_frozen_pass", if0.pass_count, 6);
    chk("done_frozen_cov", if0.coverage, 8'hE7);
    drive(1'b1, 1'b0, 1'b0, 3'b000, 2'b00);
    for (int i = 0; i < 7; i++) good(3'(i));
    chk("t2_busy7", if0.busy, 1);
    good(3'b111);
    run_exp = 1'b0;
    chk("t2_done", if0.done, 1);
    chk("t2_cov", if0.coverage, 8'hFF);
    chk("t2_pass", if0.pass_count, 8);
    chk("t2_allpass", if0.all_pass, 1);
    chk("t2_sof_allpass", if1.all_pass, 1);
    drive(1'b1, 1'b0, 1'b0, 3'b000, 2'b00);
    drive(1'b0, 1'b0, 1'b1, 3'b110, 2'b11);
    drive(1'b0, 1'b0, 1'b1, 3'b011, 2'b10);
    chk("t3_ff_after2", if0.first_fail, 5'b11011);
    idle();
    chk("t3_fail", if0.fail_count, 2);
    chk("t3_pass", if0.pass_count, 0);
    chk("t3_seen", if0.fail_seen, 1);
    chk("t3_ff", if0.first_fail, 5'b11011);
    chk("t3_busy", if0.busy, 1);
    chk("t3_sof_done", if1.done, 1);
    chk("t3_sof_fail", if1.fail_count, 1);
    chk("t3_sof_ff", if1.first_fail, 5'b11011);
    chk("t3_sof_allpass", if1.all_pass, 0);
    drive(1'b0, 1'b1, 1'b0, 3'b000, 2'b00);
    drive(1'b1, 1'b0, 1'b0, 3'b000, 2'b00);
    for (int i = 0; i < 10; i++) good(3'b000);
    drive(1'b0, 1'b1, 1'b0, 3'b000, 2'b00);
    chk("t4_sat_pass", if2.pass_count, 7);
    chk("t4_sat_cov", if2.coverage, 8'h01);
    chk("t4_sat_done", if2.done, 1);
    chk("t4_wide_pass", if0.pass_count, 10);
    drive(1'b1, 1'b0, 1'b0, 3'b000, 2'b00);
    good(3'b001);
    good(3'b010);
    good(3'b011);
    chk("t5_pass3", if0.pass_count, 3);
    drive(1'b1, 1'b0, 1'b1, 3'b111, 2'b00);
    chk("t5_restart_pass", if0.pass_count, 0);
    chk("t5_restart_fail", if0.fail_count, 0);
    chk("t5_restart_cov", if0.coverage, 0);
    chk("t5_restart_busy", if0.busy, 1);
    rst = 1'b1;
    drive(1'b0, 1'b0, 1'b1, 3'b110, 2'b11);
    rst = 1'b0;
    chk("t5_rst_busy", if0.busy, 0);
    chk("t5_rst_done", if0.done, 0);
    chk("t5_rst_seen", if0.fail_seen, 0);
    chk("t5_rst_ff", if0.first_fail, 0);
    chk("t5_rst_pass2", if2.pass_count, 0);
    good(3'b000);
    good(3'b101);
    chk("t5_idle_pass", if0.pass_count, 0);
    chk("t5_idle_cov", if0.coverage, 0);
    chk("t5_idle_busy", if0.busy, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
